vga_fb_ctrl: RTL and testbench
==============================

Name: vga_fb_ctrl

Overview:
Sequences the 4x-upscaled 160x120 framebuffer for the VGA pixel path. It owns the single-port framebuffer RAM and shares it between the display fetch (fixed timing, absolute priority) and a host write port with a valid/ready handshake. It sits between vga_core and the colour pins. It takes hcount/vcount/de/sync from vga_core and drives pipelined, blank-gated RGB plus delayed syncs.

Parameters:
HRES, 640, active pixels per line
VRES, 480, active lines per frame
HSZ, 10, hcount width
VSZ, 10, vcount width
FB_W, 160, framebuffer words per row (HRES/4)
FB_H, 120, framebuffer rows (VRES/4)
AW, 15, RAM address width (covers FB_W*FB_H = 19200)
DW, 12, pixel width, RGB444 {r[11:8], g[7:4], b[3:0]}

Ports:
clk_i  in  1  pixel clock
rst_i  in  1  synchronous active-high reset
hcount_i  in  HSZ  pixel x from vga_core
vcount_i  in  VSZ  line y from vga_core
de_i  in  1  display enable from vga_core
hsync_i  in  1  hsync from vga_core
vsync_i  in  1  vsync from vga_core
ram_addr_o  out  AW  RAM address
ram_we_o  out  1  RAM write enable
ram_wdata_o  out  DW  RAM write data
ram_rdata_i  in  DW  RAM read data, valid 1 cycle after the address
wr_valid_i  in  1  host write request
wr_ready_o  out  1  host write slot available
wr_addr_i  in  AW  host framebuffer address (row*FB_W + col)
wr_data_i  in  DW  host pixel data
o_r  out  4  red
o_g  out  4  green
o_b  out  4  blue
o_hsync  out  1  hsync, delayed 2 cycles
o_vsync  out  1  vsync, delayed 2 cycles
frame_start_o  out  1  1-cycle pulse at start of vertical blank
frame_cnt_o  out  16  frames completed, wraps

Behaviour:
- Reset (synchronous, active-high): all registered outputs go to 0, including o_r/o_g/o_b, syncs, frame_start_o, frame_cnt_o, ram_we_o and the internal pixel latch. wr_ready_o is 0 while rst_i is high. A write presented in a reset cycle is not performed.
- Fetch slot: fetch = de_i & (hcount_i[1:0] == 0) & ~rst_i.
  - Fetch address = (vcount_i>>2)*FB_W + (hcount_i>>2), built as a shift-add: (v<<7) + (v<<5) + h, truncated to AW.
  - Fetch cycle: ram_addr_o = fetch address, ram_we_o = 0.
- Arbitration: display has absolute priority.
  - wr_ready_o = ~fetch & ~rst_i (combinational).
  - A host transfer occurs on wr_valid_i & wr_ready_o. In that cycle: ram_addr_o = wr_addr_i, ram_wdata_o = wr_data_i, ram_we_o = 1.
  - If wr_addr_i >= FB_W*FB_H, the transfer is accepted (handshake completes) and ram_we_o stays 0 (dropped).
  - Idle cycles: ram_we_o = 0, ram_addr_o don't-care.
  - The host gets 3 of 4 cycles during active video and every cycle in blanking.
- Pixel pipeline, fixed latency 2:
  - fetch_d1 = fetch delayed 1 cycle.
  - When fetch_d1 is set, pix_q <= ram_rdata_i. pix_q holds for the 4 pixels of the group.
  - de, hsync, vsync are each delayed 2 cycles (de_d2, o_hsync, o_vsync).
  - {o_r, o_g, o_b} = de_d2 ? pix_q : 0, registered so outputs align with the delayed syncs.
  - Pixel x at cycle t appears at cycle t+2.
- Vertical repeat: every line refetches; the 4 lines of a row reuse the same addresses. No line buffer.
- frame_start_o: pulses for 1 cycle when hcount_i == 0 and vcount_i == VRES. frame_cnt_o increments (mod 2^16) in the same cycle, visible next cycle.
- Write/read collision on the same address: impossible by construction, since there is one access per cycle. A write at cycle t is visible to any fetch at t+1 or later.
- Host must hold wr_addr_i/wr_data_i stable while wr_valid_i is high and not yet accepted. wr_valid_i may change freely after acceptance.

Test Plan:
1. Reset held 3 cycles with wr_valid_i=1 -> ram_we_o=0, wr_ready_o=0, RGB=0, frame_cnt_o=0; no RAM contents change.
2. Preload RAM[0]=0xF00, RAM[1]=0x0F0; drive line 0 with x=0..7 -> o_r=F for output cycles of x=0..3, o_g=F for x=4..7, both exactly 2 cycles after the corresponding hcount.
3. Line y=5, x=8 -> fetch address = 1*160 + 2 = 162. Line y=479, x=636 -> address 119*160 + 159 = 19199.
4. Continuous wr_valid_i during active video -> wr_ready_o low exactly when hcount[1:0]==0; 3 writes accepted per 4 cycles, all ready during blanking.
5. Write to addr 19200 -> handshake completes, ram_we_o=0. Write 0xABC to addr 0 in blanking, then display line 0 -> RGB = A,B,C at x=0..3.
6. Run 2 full frames -> exactly one frame_start_o pulse per frame at (0, 480); frame_cnt_o=2. Force frame_cnt_o near 0xFFFF -> it wraps to 0.

Source files
------------

// File: rtl/vga_fb_ctrl.sv
// vga_fb_ctrl: owns the single-port framebuffer RAM behind a 4x-upscaled
// 160x120 RGB444 image. The display fetch has absolute priority and uses
// one RAM cycle in every 4 during active video. The host write port takes
// all remaining cycles through a valid/ready handshake.
//
// Ports:
//   clk_i, rst_i               pixel clock, synchronous active-high reset
//   hcount_i, vcount_i         pixel position from vga_core
//   de_i, hsync_i, vsync_i     display enable and syncs from vga_core
//   ram_addr_o/we_o/wdata_o    RAM request; ram_rdata_i returns 1 cycle later
//   wr_valid_i/wr_ready_o      host write handshake
//   wr_addr_i, wr_data_i       host address (row*FB_W + col) and pixel
//   o_r, o_g, o_b              blank-gated colour, 2 cycles after hcount_i
//   o_hsync, o_vsync           syncs delayed 2 cycles to line up with colour
//   frame_start_o              1-cycle pulse when vertical blank begins
//   frame_cnt_o                completed frame count, wraps at 16 bits
module vga_fb_ctrl #(
  parameter int HRES = 640,
  parameter int VRES = 480,
  parameter int HSZ  = 10,
  parameter int VSZ  = 10,
  parameter int FB_W = HRES / 4,
  parameter int FB_H = VRES / 4,
  parameter int AW   = 15,
  parameter int DW   = 12
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [HSZ-1:0] hcount_i,
  input  logic [VSZ-1:0] vcount_i,
  input  logic           de_i,
  input  logic           hsync_i,
  input  logic           vsync_i,
  output logic [AW-1:0]  ram_addr_o,
  output logic           ram_we_o,
  output logic [DW-1:0]  ram_wdata_o,
  input  logic [DW-1:0]  ram_rdata_i,
  input  logic           wr_valid_i,
  output logic           wr_ready_o,
  input  logic [AW-1:0]  wr_addr_i,
  input  logic [DW-1:0]  wr_data_i,
  output logic [3:0]     o_r,
  output logic [3:0]     o_g,
  output logic [3:0]     o_b,
  output logic           o_hsync,
  output logic           o_vsync,
  output logic           frame_start_o,
  output logic [15:0]    frame_cnt_o
);

  localparam int FB_SIZE = FB_W * FB_H;

  logic          fetch;
  logic [AW-1:0] fb_row;
  logic [AW-1:0] fb_col;
  logic [AW-1:0] fetch_addr;
  logic          wr_in_range;
  logic          frame_hit;

  logic          fetch_d1;
  logic [DW-1:0] pix_q;
  logic [DW-1:0] pix_now;
  logic          de_d1;
  logic          hs_d1;
  logic          vs_d1;
  logic [DW-1:0] rgb_q;

  // The two low vcount bits select the repeated line within a row, which
  // reuses the same fetch addresses.
  logic unused_vbits;
  assign unused_vbits = ^vcount_i[1:0];

  // One fetch per group of 4 horizontal pixels.
  assign fetch = de_i & (hcount_i[1:0] == 2'b00) & ~rst_i;

  // row*160 as (row<<7)+(row<<5), avoiding a multiplier.
  assign fb_row     = AW'(vcount_i[VSZ-1:2]);
  assign fb_col     = AW'(hcount_i[HSZ-1:2]);
  assign fetch_addr = (fb_row << 7) + (fb_row << 5) + fb_col;

  assign wr_ready_o  = ~fetch & ~rst_i;
  assign wr_in_range = (wr_addr_i < AW'(FB_SIZE));

  // Out-of-range host writes still complete the handshake but never reach
  // the RAM.
  always_comb begin
    ram_addr_o  = wr_addr_i;
    ram_we_o    = 1'b0;
    ram_wdata_o = wr_data_i;
    if (fetch) begin
      ram_addr_o = fetch_addr;
    end else if (wr_valid_i & wr_ready_o & wr_in_range) begin
      ram_we_o = 1'b1;
    end
  end

  // The read data for a group arrives one cycle after its fetch. It is used
  // directly for the first pixel and held in pix_q for the other three.
  // That keeps the total latency at 2 cycles.
  assign pix_now = fetch_d1 ? ram_rdata_i : pix_q;

  assign frame_hit = (hcount_i == '0) & (vcount_i == VSZ'(VRES)) & ~rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_d1      <= 1'b0;
      pix_q         <= '0;
      de_d1         <= 1'b0;
      hs_d1         <= 1'b0;
      vs_d1         <= 1'b0;
      o_hsync       <= 1'b0;
      o_vsync       <= 1'b0;
      rgb_q         <= '0;
      frame_start_o <= 1'b0;
      frame_cnt_o   <= '0;
    end else begin
      fetch_d1 <= fetch;
      if (fetch_d1) begin
        pix_q <= ram_rdata_i;
      end
      de_d1   <= de_i;
      hs_d1   <= hsync_i;
      vs_d1   <= vsync_i;
      o_hsync <= hs_d1;
      o_vsync <= vs_d1;
      // Blank gating uses de delayed once here. The registered result
      // therefore carries de delayed twice, alongside the syncs.
      rgb_q         <= de_d1 ? pix_now : '0;
      frame_start_o <= frame_hit;
      frame_cnt_o   <= frame_cnt_o + 16'(frame_hit);
    end
  end

  assign o_r = rgb_q[11:8];
  assign o_g = rgb_q[7:4];
  assign o_b = rgb_q[3:0];

endmodule

// File: tb/tb_vga_fb_ctrl.sv
module tb_vga_fb_ctrl;

  localparam int FB_SIZE = 19200;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [9:0]  hcount_i;
  logic [9:0]  vcount_i;
  logic        de_i;
  logic        hsync_i;
  logic        vsync_i;
  logic [14:0] ram_addr_o;
  logic        ram_we_o;
  logic [11:0] ram_wdata_o;
  logic [11:0] ram_rdata_i;
  logic        wr_valid_i;
  logic        wr_ready_o;
  logic [14:0] wr_addr_i;
  logic [11:0] wr_data_i;
  logic [3:0]  o_r;
  logic [3:0]  o_g;
  logic [3:0]  o_b;
  logic        o_hsync;
  logic        o_vsync;
  logic        frame_start_o;
  logic [15:0] frame_cnt_o;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [11:0] ram_mem [0:FB_SIZE-1];
  logic [11:0] shadow  [0:FB_SIZE-1];

  typedef struct {
    int          due;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
  } exp_t;
  exp_t sbq[$];

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Synchronous single-port RAM, 1-cycle read latency.
  always @(posedge clk_i) begin
    if (ram_we_o && ram_addr_o < FB_SIZE) ram_mem[ram_addr_o] <= ram_wdata_o;
    ram_rdata_i <= (ram_addr_o < FB_SIZE) ? ram_mem[ram_addr_o] : 12'h000;
  end

  vga_fb_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .hcount_i(hcount_i), .vcount_i(vcount_i),
    .de_i(de_i), .hsync_i(hsync_i), .vsync_i(vsync_i),
    .ram_addr_o(ram_addr_o), .ram_we_o(ram_we_o), .ram_wdata_o(ram_wdata_o),
    .ram_rdata_i(ram_rdata_i), .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
    .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .o_r(o_r), .o_g(o_g), .o_b(o_b), .o_hsync(o_hsync), .o_vsync(o_vsync),
    .frame_start_o(frame_start_o), .frame_cnt_o(frame_cnt_o)
  );

  function automatic logic [11:0] exp_pix(int h, int v, bit de);
    return de ? shadow[(v / 4) * 160 + h / 4] : 12'h000;
  endfunction

  task automatic set_vid(int h, int v, bit de, bit hs, bit vs);
    hcount_i = 10'(h);
    vcount_i = 10'(v);
    de_i     = de;
    hsync_i  = hs;
    vsync_i  = vs;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    wr_valid_i = 1'b1;
    wr_addr_i = 15'd5;
    wr_data_i = 12'h123;
    set_vid(1, 0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      checks++;
      if (ram_we_o !== 1'b0) begin
        failures++; $display("FAIL reset_we got=%b want=0", ram_we_o);
      end
      checks++;
      if (wr_ready_o !== 1'b0) begin
        failures++; $display("FAIL reset_ready got=%b want=0", wr_ready_o);
      end
      checks++;
      if ({o_r, o_g, o_b} !== 12'h000) begin
        failures++; $display("FAIL reset_rgb got=%h want=000", {o_r, o_g, o_b});
      end
      checks++;
      if (frame_cnt_o !== 16'h0 || o_hsync !== 1'b0 || frame_start_o !== 1'b0) begin
        failures++;
        $display("FAIL reset_regs cnt=%h hs=%b fs=%b want 0", frame_cnt_o, o_hsync, frame_start_o);
      end
    end
    rst_i = 1'b0;
    wr_valid_i = 1'b0;
    set_vid(0, 500, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    checks++;
    if (ram_mem[5] !== 12'h000) begin
      failures++; $display("FAIL reset_nowrite got=%h want=000", ram_mem[5]);
    end
  endtask

  // Drives one line segment and checks colour/sync 2 cycles later.
  task automatic test_pixels(string name, int v, int x0, int n_act);
    int n_tot;
    exp_t e;
    n_tot = n_act + 6;
    for (int i = 0; i < n_tot + 3; i++) begin
      @(negedge clk_i);
      while (sbq.size() > 0 && sbq[0].due <= cyc) begin
        e = sbq.pop_front();
        if (e.due == cyc) begin
          checks++;
          if ({o_r, o_g, o_b} !== e.rgb) begin
            failures++;
            $display("FAIL %s_rgb cyc=%0d got=%h want=%h", name, cyc, {o_r, o_g, o_b}, e.rgb);
          end
          checks++;
          if (o_hsync !== e.hs || o_vsync !== e.vs) begin
            failures++;
            $display("FAIL %s_sync cyc=%0d got=%b%b want=%b%b", name, cyc, o_hsync, o_vsync, e.hs, e.vs);
          end
        end
      end
      if (i < n_tot) begin
        bit de, hs, vs;
        de = (i < n_act);
        hs = (i == n_act + 1) || (i == n_act + 2);
        vs = (i == n_act + 2);
        set_vid(x0 + i, v, de, hs, vs);
        e.due = cyc + 2;
        e.rgb = exp_pix(x0 + i, v, de);
        e.hs = hs;
        e.vs = vs;
        sbq.push_back(e);
      end else begin
        set_vid(0, 500, 1'b0, 1'b0, 1'b0);
      end
    end
    checks++;
    if (sbq.size() != 0) begin
      failures++; $display("FAIL %s_drain got=%0d want=0 pending", name, sbq.size());
    end
  endtask

  task automatic test_fetch_addr();
    int hs[3] = '{8, 636, 4};
    int vs[3] = '{5, 479, 0};
    int ea[3] = '{162, 19199, 1};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      set_vid(hs[i], vs[i], 1'b1, 1'b0, 1'b0);
      #1;
      checks++;
      if (ram_addr_o !== 15'(ea[i]) || ram_we_o !== 1'b0 || wr_ready_o !== 1'b0) begin
        failures++;
        $display("FAIL fetch_addr got=%0d we=%b rdy=%b want=%0d we=0 rdy=0",
                 ram_addr_o, ram_we_o, wr_ready_o, ea[i]);
      end
    end
    @(negedge clk_i);
    set_vid(0, 500, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_arbitration();
    int acc_act = 0;
    int acc_blk = 0;
    bit adv = 0;
    logic [14:0] a = 15'd1000;
    logic [11:0] d = 12'h100;
    wr_valid_i = 1'b1;
    for (int i = 0; i < 24; i++) begin
      bit act;
      bit exp_rdy;
      @(negedge clk_i);
      if (adv) begin a = a + 15'd1; d = d + 12'h001; end
      adv = 0;
      act = (i < 16);
      wr_addr_i = a;
      wr_data_i = d;
      set_vid(act ? i : 700 + i, 8, act, 1'b0, 1'b0);
      #1;
      exp_rdy = !(act && (i % 4 == 0));
      checks++;
      if (wr_ready_o !== exp_rdy) begin
        failures++; $display("FAIL arb_ready i=%0d got=%b want=%b", i, wr_ready_o, exp_rdy);
      end
      if (!exp_rdy) begin
        checks++;
        if (ram_addr_o !== 15'(320 + i / 4) || ram_we_o !== 1'b0) begin
          failures++;
          $display("FAIL arb_fetch i=%0d addr=%0d we=%b want=%0d we=0", i, ram_addr_o, ram_we_o, 320 + i / 4);
        end
      end
      if (wr_ready_o === 1'b1) begin
        adv = 1;
        shadow[a] = d;
        if (act) acc_act++; else acc_blk++;
      end
    end
    @(negedge clk_i);
    wr_valid_i = 1'b0;
    set_vid(0, 500, 1'b0, 1'b0, 1'b0);
    checks++;
    if (acc_act != 12 || acc_blk != 8) begin
      failures++; $display("FAIL arb_count act=%0d blk=%0d want 12 8", acc_act, acc_blk);
    end
    @(negedge clk_i);
    for (int k = 0; k < 20; k++) begin
      checks++;
      if (ram_mem[1000 + k] !== shadow[1000 + k]) begin
        failures++;
        $display("FAIL arb_mem addr=%0d got=%h want=%h", 1000 + k, ram_mem[1000 + k], shadow[1000 + k]);
      end
    end
  endtask

  task automatic test_write_oob();
    @(negedge clk_i);
    set_vid(0, 500, 1'b0, 1'b0, 1'b0);
    wr_valid_i = 1'b1;
    wr_addr_i = 15'd19200;
    wr_data_i = 12'h555;
    #1;
    checks++;
    if (wr_ready_o !== 1'b1 || ram_we_o !== 1'b0) begin
      failures++; $display("FAIL oob_write rdy=%b we=%b want rdy=1 we=0", wr_ready_o, ram_we_o);
    end
    @(negedge clk_i);
    wr_addr_i = 15'd0;
    wr_data_i = 12'hABC;
    #1;
    checks++;
    if (ram_we_o !== 1'b1 || ram_addr_o !== 15'd0 || ram_wdata_o !== 12'hABC) begin
      failures++;
      $display("FAIL blank_write we=%b addr=%0d data=%h want 1 0 abc", ram_we_o, ram_addr_o, ram_wdata_o);
    end
    shadow[0] = 12'hABC;
    @(negedge clk_i);
    wr_valid_i = 1'b0;
  endtask

  task automatic test_frames();
    int fh[7] = '{5, 0, 1, 2, 0, 0, 1};
    int fv[7] = '{479, 480, 480, 480, 481, 0, 0};
    bit hit_prev = 0;
    int pulses = 0;
    logic [15:0] exp_cnt;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 7; i++) begin
        @(negedge clk_i);
        checks++;
        if (frame_start_o !== hit_prev) begin
          failures++; $display("FAIL frame_start got=%b want=%b", frame_start_o, hit_prev);
        end
        if (frame_start_o === 1'b1) pulses++;
        set_vid(fh[i], fv[i], 1'b0, 1'b0, 1'b0);
        hit_prev = (fh[i] == 0 && fv[i] == 480);
      end
    end
    @(negedge clk_i);
    if (frame_start_o === 1'b1) pulses++;
    checks++;
    if (pulses != 2 || frame_cnt_o !== 16'd2) begin
      failures++; $display("FAIL frame_count pulses=%0d cnt=%0d want 2 2", pulses, frame_cnt_o);
    end
    exp_cnt = 16'd2;
    for (int i = 0; i < 65533; i++) begin
      set_vid(0, 480, 1'b0, 1'b0, 1'b0);
      exp_cnt = exp_cnt + 16'd1;
      @(negedge clk_i);
    end
    set_vid(1, 480, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    checks++;
    if (frame_cnt_o !== exp_cnt || exp_cnt !== 16'hFFFF) begin
      failures++; $display("FAIL frame_cnt_max got=%h want=ffff", frame_cnt_o);
    end
    set_vid(0, 480, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    set_vid(1, 480, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    checks++;
    if (frame_cnt_o !== 16'h0000) begin
      failures++; $display("FAIL frame_cnt_wrap got=%h want=0000", frame_cnt_o);
    end
  endtask

  initial begin
    for (int i = 0; i < FB_SIZE; i++) begin
      ram_mem[i] = 12'h000;
      shadow[i]  = 12'h000;
    end
    test_reset();
    ram_mem[0] = 12'hF00; shadow[0] = 12'hF00;
    ram_mem[1] = 12'h0F0; shadow[1] = 12'h0F0;
    ram_mem[40] = 12'h00F; shadow[40] = 12'h00F;
    ram_mem[41] = 12'h5A3; shadow[41] = 12'h5A3;
    test_pixels("line0", 0, 0, 8);
    test_pixels("row0_repeat", 3, 0, 8);
    test_pixels("midline", 1, 160, 8);
    test_fetch_addr();
    test_arbitration();
    test_write_oob();
    test_pixels("after_write", 0, 0, 4);
    test_frames();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
